// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate clock enable, scan counters and
// registered sync/blanking/strobe outputs, all decoded from next-state counts.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [10:0] HLast    = 11'(HTotal - 1);
  localparam logic [10:0] VLast    = 11'(VTotal - 1);
  localparam logic [10:0] HAct     = 11'(H_ACTIVE);
  localparam logic [10:0] VAct     = 11'(V_ACTIVE);
  localparam logic [10:0] HsFirst  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsLast   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VsFirst  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsLast   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (HTotal > 2047 || VTotal > 2047) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 2047");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end

  logic [DivW-1:0] div_q, div_d;
  logic [10:0]     h_q, h_d;
  logic [10:0]     v_q, v_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            von_q, von_d;
  logic            tick_q, tick_d;
  logic            ls_q, ls_d;
  logic            fs_q, fs_d;
  logic            adv;

  always_comb begin
    adv   = (div_q == DivLast);
    div_d = adv ? '0 : div_q + DivW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (adv) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
    // Decode from next counts so every output changes on the same edge.
    hs_d   = ((h_d >= HsFirst) && (h_d <= HsLast)) ? HS_POL : ~HS_POL;
    vs_d   = ((v_d >= VsFirst) && (v_d <= VsLast)) ? VS_POL : ~VS_POL;
    von_d  = (h_d < HAct) && (v_d < VAct);
    tick_d = adv;
    ls_d   = adv && (h_d == '0);
    fs_d   = adv && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      h_q    <= HLast;
      v_q    <= VLast;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      von_q  <= 1'b0;
      tick_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
      tick_q <= tick_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  assign pix_tick    = tick_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a standard 640x480 instance (CLK_DIV=2) and a small
// fast-framing instance (CLK_DIV=1, active-high syncs) checked against a time-based model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        tick;
    logic        ls;
    logic        fs;
  } out_t;

  logic clk;
  logic rst_n;

  logic [10:0] a_x, a_y, b_x, b_y;
  logic a_hs, a_vs, a_von, a_tick, a_ls, a_fs;
  logic b_hs, b_vs, b_von, b_tick, b_ls, b_fs;

  int checks;
  int errors;
  int cyc;
  int paint_cnt;
  bit seen_fs;
  out_t q_a[$];
  out_t q_b[$];

  vga_sync_gen u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (a_x),
    .pix_y      (a_y),
    .hsync      (a_hs),
    .vsync      (a_vs),
    .video_on   (a_von),
    .pix_tick   (a_tick),
    .line_start (a_ls),
    .frame_start(a_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(1),   .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (b_x),
    .pix_y      (b_y),
    .hsync      (b_hs),
    .vsync      (b_vs),
    .video_on   (b_von),
    .pix_tick   (b_tick),
    .line_start (b_ls),
    .frame_start(b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs n active clk edges after reset release (n=0: in reset).
  function automatic out_t ref_out(int n, int d, int ha, int hf, int hw, int hb,
                                   int va, int vf, int vw, int vb, bit hp, bit vp);
    int ht, vt, tot, pos, x, y;
    out_t o;
    ht    = ha + hf + hw + hb;
    vt    = va + vf + vw + vb;
    tot   = ht * vt;
    pos   = ((n / d) - 1 + tot) % tot;
    x     = pos % ht;
    y     = pos / ht;
    o.x   = 11'(x);
    o.y   = 11'(y);
    o.hs  = (x >= ha + hf && x < ha + hf + hw) ? hp : ~hp;
    o.vs  = (y >= va + vf && y < va + vf + vw) ? vp : ~vp;
    o.von = (x < ha) && (y < va);
    o.tick = (n > 0) && (n % d == 0);
    o.ls  = o.tick && (x == 0);
    o.fs  = o.tick && (pos == 0);
    return o;
  endfunction

  function automatic out_t ref_a(int n);
    return ref_out(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  function automatic out_t ref_b(int n);
    return ref_out(n, 1, 16, 2, 3, 3, 8, 1, 2, 2, 1'b1, 1'b1);
  endfunction

  task automatic cmp_out(input string tag, input out_t got, input out_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b von=%b tk=%b ls=%b fs=%b exp x=%0d y=%0d hs=%b vs=%b von=%b tk=%b ls=%b fs=%b",
             tag, cyc, got.x, got.y, got.hs, got.vs, got.von, got.tick, got.ls, got.fs,
             exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.tick, exp.ls, exp.fs);
    end
  endtask

  task automatic cmp_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic out_t obs_a();
    return '{a_x, a_y, a_hs, a_vs, a_von, a_tick, a_ls, a_fs};
  endfunction

  function automatic out_t obs_b();
    return '{b_x, b_y, b_hs, b_vs, b_von, b_tick, b_ls, b_fs};
  endfunction

  // 4x2 sprite at (14,6) on the small raster; only 2x2 of it lies in the visible area.
  task automatic painter_b();
    if (b_fs) begin
      if (seen_fs) cmp_int("paint_per_frame", paint_cnt, 4);
      paint_cnt = 0;
      seen_fs   = 1'b1;
    end
    if (b_von && b_x >= 14 && b_x <= 17 && b_y >= 6 && b_y <= 7) paint_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) cyc++;
    q_a.push_back(ref_a(cyc));
    q_b.push_back(ref_b(cyc));
    @(negedge clk);
    cmp_out("dut_a", obs_a(), q_a.pop_front());
    cmp_out("dut_b", obs_b(), q_b.pop_front());
    painter_b();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    paint_cnt = 0;
    seen_fs   = 1'b0;
    rst_n     = 1'b1;

    // Async assertion before any clk edge.
    #2 rst_n = 1'b0;
    #1;
    cmp_out("rst_async_a", obs_a(), ref_a(0));
    cmp_out("rst_async_b", obs_b(), ref_b(0));

    repeat (3) step();
    rst_n = 1'b1;

    // Two full lines of the 640x480 raster; several frames of the small one.
    while (cyc < 2 * 1600 + 10) step();

    // Walk to (320,2) on the big raster, then reset between clk edges.
    while (cyc < 2 * (2 * 800 + 320 + 1)) step();
    cmp_int("pre_rst_x", int'(a_x), 320);
    #2 rst_n = 1'b0;
    cyc     = 0;
    seen_fs = 1'b0;
    #1;
    cmp_out("rst_mid_a", obs_a(), ref_a(0));
    cmp_out("rst_mid_b", obs_b(), ref_b(0));
    repeat (2) step();
    rst_n = 1'b1;

    // Restart must repeat the first-release timing.
    while (cyc < 1700) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
